// File: rtl/pc_gen.sv
// pc_gen: program-counter generator and fetch sequencer (optional RVC stepping via PC_GEN_RVC_EN)
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET     = '0,
    parameter logic [3:0]      MIS_CAUSE = 4'd0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] alu_o,
    input  logic            alu_z,
    input  logic            s_jump,
    input  logic            s_jalr,
    input  logic            s_branch,
    input  logic            s_branch_zero,
    input  logic [XLEN-1:0] imm,
    input  logic            trap,
    input  logic [3:0]      trap_cause,
    input  logic            mret,
    input  logic [XLEN-1:0] mtvec,
    input  logic            fetch_ready,
`ifdef PC_GEN_RVC_EN
    input  logic            is_compressed,
`endif
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] mepc,
    output logic [3:0]      mcause,
    output logic            misaligned
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
    state_t          state, state_n;
    logic [XLEN-1:0] pc_n, mepc_n, step, jump_tgt, br_tgt, tgt;
    logic [3:0]      mcause_n;
    logic            mis_n, taken, ctl, bad, advance;
`ifdef PC_GEN_RVC_EN
    assign step = is_compressed ? XLEN'(2) : XLEN'(4);
    assign bad  = tgt[0];
`else
    assign step = XLEN'(4);
    assign bad  = |tgt[1:0];
`endif
    assign next_pc     = pc + step;
    assign taken       = s_branch & (s_branch_zero ? alu_z : ~alu_z);
    assign jump_tgt    = s_jalr ? (alu_o & ~XLEN'(1)) : alu_o;
    assign br_tgt      = pc + imm;
    assign tgt         = s_jump ? jump_tgt : br_tgt;
    assign ctl         = s_jump | taken;
    assign advance     = (state == RUN) & fetch_ready & ~stall;
    assign fetch_valid = state == RUN;
    // next-state selection: trap beats mret beats misaligned beats jump/branch/sequential
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        mepc_n   = mepc;
        mcause_n = mcause;
        mis_n    = 1'b0;
        if (state == BOOT) begin
            state_n = RUN;
        end else if (state == TRAP) begin
            state_n = RUN;
            pc_n    = mtvec & ~XLEN'(3);
        end else if (trap) begin
            state_n  = TRAP;
            mepc_n   = pc;
            mcause_n = trap_cause;
        end else if (advance) begin
            if (mret) begin
                pc_n = mepc;
            end else if (ctl && bad) begin
                state_n  = TRAP;
                mepc_n   = pc;
                mcause_n = MIS_CAUSE;
                mis_n    = 1'b1;
            end else begin
                pc_n = ctl ? tgt : next_pc;
            end
        end
    end
    // state and architectural registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc         <= RESET;
            mepc       <= '0;
            mcause     <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            mepc       <= mepc_n;
            mcause     <= mcause_n;
            misaligned <= mis_n;
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard-driven bench for pc_gen
module tb_pc_gen;
    localparam logic [31:0] RST = 32'h8000_0000;
    logic        clock = 1'b0, reset = 1'b0, stall = 1'b0;
    logic [31:0] alu_o = '0, imm = '0, mtvec = '0;
    logic        alu_z = 1'b0, s_jump = 1'b0, s_jalr = 1'b0, s_branch = 1'b0, s_branch_zero = 1'b0;
    logic        trap = 1'b0, mret = 1'b0, fetch_ready = 1'b0;
    logic [3:0]  trap_cause = '0;
`ifdef PC_GEN_RVC_EN
    logic        is_compressed = 1'b0;
`endif
    logic        fetch_valid, misaligned;
    logic [31:0] pc, next_pc, mepc;
    logic [3:0]  mcause;
    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];

    pc_gen #(.XLEN(32), .RESET(RST), .MIS_CAUSE(4'd0)) dut (
        .clock(clock), .reset(reset), .stall(stall), .alu_o(alu_o), .alu_z(alu_z),
        .s_jump(s_jump), .s_jalr(s_jalr), .s_branch(s_branch), .s_branch_zero(s_branch_zero),
        .imm(imm), .trap(trap), .trap_cause(trap_cause), .mret(mret), .mtvec(mtvec),
        .fetch_ready(fetch_ready),
`ifdef PC_GEN_RVC_EN
        .is_compressed(is_compressed),
`endif
        .fetch_valid(fetch_valid), .pc(pc), .next_pc(next_pc), .mepc(mepc),
        .mcause(mcause), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        stall = 0; alu_o = '0; imm = '0; alu_z = 0; s_jump = 0; s_jalr = 0;
        s_branch = 0; s_branch_zero = 0; trap = 0; trap_cause = '0; mret = 0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        idle(); fetch_ready = 1; reset = 0;
        #12;
        total++; if (pc !== RST) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, RST); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", fetch_valid); end
        total++; if ({mepc, mcause, misaligned} !== '0) begin bad++; $display("FAIL reset_csr got=%h/%h/%b want=0", mepc, mcause, misaligned); end
        @(negedge clock); reset = 1;
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_fv got=%b want=0", fetch_valid); end
        for (int i = 0; i < 3; i++) exp_q.push_back(RST + 32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            total++; if (fetch_valid !== 1'b1 || pc !== e) begin bad++; $display("FAIL seq_pc got=%h/%b want=%h/1", pc, fetch_valid, e); end
            total++; if (next_pc !== e + 32'd4) begin bad++; $display("FAIL seq_next got=%h want=%h", next_pc, e + 32'd4); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] e;
        logic [2:0]  bz_tbl = 3'b011, z_tbl = 3'b001;
        logic [31:0] want[3] = '{32'h0F8, 32'h104, 32'h0F8};
        for (int i = 0; i < 3; i++) begin
            s_jump = 1; alu_o = 32'h100; exp_q.push_back(32'h100);
            @(negedge clock); idle();
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL br_setup got=%h want=%h", pc, e); end
            s_branch = 1; s_branch_zero = bz_tbl[i]; alu_z = z_tbl[i]; imm = -32'sd8;
            exp_q.push_back(want[i]);
            @(negedge clock); idle();
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL branch%0d got=%h want=%h", i, pc, e); end
        end
    endtask

    task automatic test_jalr_stall();
        logic [31:0] e;
        for (int k = 0; k < 2; k++) begin
            s_jump = 1; alu_o = 32'h200; exp_q.push_back(32'h200);
            @(negedge clock); idle();
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL jalr_setup got=%h want=%h", pc, e); end
            s_jump = 1; s_jalr = 1; alu_o = 32'h301; stall = (k == 1);
            if (k == 1) begin
                for (int i = 0; i < 3; i++) exp_q.push_back(32'h200);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    e = exp_q.pop_front();
                    total++; if (pc !== e) begin bad++; $display("FAIL stall_hold got=%h want=%h", pc, e); end
                end
                stall = 0;
            end
            exp_q.push_back(32'h300);
            @(negedge clock); idle();
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL jalr%0d got=%h want=%h", k, pc, e); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] e;
        mtvec = 32'h1003;
        s_jump = 1; alu_o = 32'h40; exp_q.push_back(32'h40);
        @(negedge clock); idle();
        e = exp_q.pop_front();
        total++; if (pc !== e) begin bad++; $display("FAIL mis_setup got=%h want=%h", pc, e); end
        s_jump = 1; alu_o = 32'h122;
`ifdef PC_GEN_RVC_EN
        exp_q.push_back(32'h122);
        @(negedge clock); idle();
        e = exp_q.pop_front();
        total++; if (pc !== e || misaligned !== 1'b0) begin bad++; $display("FAIL rvc_tgt got=%h/%b want=%h/0", pc, misaligned, e); end
`else
        exp_q.push_back(32'h1000);
        @(negedge clock); idle();
        total++; if (misaligned !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b/%b want=1/0", misaligned, fetch_valid); end
        total++; if (mepc !== 32'h40 || mcause !== 4'd0) begin bad++; $display("FAIL mis_csr got=%h/%h want=40/0", mepc, mcause); end
        @(negedge clock);
        e = exp_q.pop_front();
        total++; if (misaligned !== 1'b0 || fetch_valid !== 1'b1 || pc !== e) begin bad++; $display("FAIL mis_vec got=%h/%b/%b want=%h/0/1", pc, misaligned, fetch_valid, e); end
`endif
    endtask

    task automatic test_trap_mret();
        logic [31:0] e;
        mtvec = 32'h1003;
        s_jump = 1; alu_o = 32'h500; exp_q.push_back(32'h500);
        @(negedge clock); idle();
        e = exp_q.pop_front();
        total++; if (pc !== e) begin bad++; $display("FAIL trap_setup got=%h want=%h", pc, e); end
        fetch_ready = 0; trap = 1; trap_cause = 4'd11; mret = 1;
        @(negedge clock); idle(); fetch_ready = 1;
        total++; if (fetch_valid !== 1'b0 || mepc !== 32'h500 || mcause !== 4'd11) begin bad++; $display("FAIL trap_entry got=%b/%h/%h want=0/500/b", fetch_valid, mepc, mcause); end
        exp_q.push_back(32'h1000);
        @(negedge clock);
        e = exp_q.pop_front();
        total++; if (fetch_valid !== 1'b1 || pc !== e) begin bad++; $display("FAIL trap_vec got=%h/%b want=%h/1", pc, fetch_valid, e); end
        mret = 1; exp_q.push_back(32'h500);
        @(negedge clock); idle();
        e = exp_q.pop_front();
        total++; if (pc !== e) begin bad++; $display("FAIL mret got=%h want=%h", pc, e); end
    endtask

    task automatic test_reset_in_trap();
        logic [31:0] e;
        trap = 1; trap_cause = 4'd3;
        @(negedge clock); idle();
        total++; if (fetch_valid !== 1'b0 || mcause !== 4'd3) begin bad++; $display("FAIL pre_rst got=%b/%h want=0/3", fetch_valid, mcause); end
        #2 reset = 0;
        #1;
        total++; if (pc !== RST || mepc !== '0 || mcause !== '0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL async_rst got=%h/%h/%h/%b want=%h/0/0/0", pc, mepc, mcause, fetch_valid, RST); end
        @(negedge clock); reset = 1;
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reboot_fv got=%b want=0", fetch_valid); end
        exp_q.push_back(RST); exp_q.push_back(RST + 32'd4);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            total++; if (fetch_valid !== 1'b1 || pc !== e) begin bad++; $display("FAIL reboot_pc got=%h/%b want=%h/1", pc, fetch_valid, e); end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr_stall();
        test_misaligned();
        test_trap_mret();
        test_reset_in_trap();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator and fetch sequencer for the RV32/RV64 core, replacing the free-running PC register.
- Computes the next PC from sequential, branch, jump/jalr, trap-entry and mret sources.
- Holds the PC under stall or instruction-memory backpressure via a valid/ready fetch handshake.
- Detects misaligned control-flow targets and turns them into trap entries; captures mepc/mcause for the CSR file.

Parameters:
XLEN, 32, datapath and PC width (32 or 64)
RESET, {XLEN{1'b0}}, PC value loaded on reset
MIS_CAUSE, 4'd0, cause code reported for an instruction-address-misaligned trap

Ports:
clock  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
stall  in  1  pipeline hold from hazard unit; PC frozen while high
alu_o  in  XLEN  jump target from ALU
alu_z  in  1  ALU zero flag
s_jump  in  1  current instruction is jal/jalr
s_jalr  in  1  current instruction is jalr (clear target bit 0)
s_branch  in  1  current instruction is a conditional branch
s_branch_zero  in  1  1: taken when alu_z=1; 0: taken when alu_z=0
imm  in  XLEN  branch offset, sign-extended
trap  in  1  external/exception trap request
trap_cause  in  4  cause code accompanying trap
mret  in  1  return from trap
mtvec  in  XLEN  trap vector base (direct mode; bits[1:0] ignored)
fetch_ready  in  1  instruction memory accepts current pc
fetch_valid  out  1  pc is a valid fetch address
pc  out  XLEN  current PC register
next_pc  out  XLEN  pc + step (link value for jal/jalr)
mepc  out  XLEN  PC of the trapping instruction
mcause  out  4  cause of the last trap
misaligned  out  1  one-cycle pulse when a misaligned target is detected

Behaviour:
- Reset (async, active-low) values: pc=RESET, mepc=0, mcause=0, misaligned=0, fetch_valid=0, state=BOOT.
- States:
  - BOOT: fetch_valid=0. Always moves to RUN on the next edge; pc unchanged.
  - RUN: fetch_valid=1.
  - TRAP: fetch_valid=0. pc<=mtvec with bits[1:0]=0; next state RUN. One bubble cycle per trap.
- step = 4. next_pc = pc + step, wraps modulo 2^XLEN.
- Control-flow terms (all evaluated in RUN):
  - taken = s_branch & (s_branch_zero ? alu_z : ~alu_z)
  - jump target = s_jalr ? (alu_o & ~1) : alu_o
  - branch target = pc + imm, modulo 2^XLEN
- advance = RUN & fetch_ready & ~stall.
- Priority in RUN, highest first:
  1. trap: state<=TRAP, mepc<=pc, mcause<=trap_cause. Sampled even when advance=0 (stall/backpressure do not block traps).
  2. mret: when advance, pc<=mepc.
  3. misaligned: when advance and the selected jump/taken-branch target has bits[1:0]!=0 → state<=TRAP, mepc<=pc, mcause<=MIS_CAUSE, misaligned=1 for that cycle. pc is not loaded with the bad target.
  4. jump: when advance, pc<=jump target.
  5. taken branch: when advance, pc<=branch target.
  6. otherwise: when advance, pc<=next_pc.
- When advance=0 and no trap: pc, mepc, mcause hold.
- trap and mret in the same cycle: trap wins, mret dropped.
- trap, mret, s_jump and s_branch are ignored in BOOT and TRAP.
- misaligned is registered: asserted on the edge that enters TRAP, deasserted on the next edge.
- Reset asserted mid-operation (any state): immediate return to the reset values; pending trap is lost.

Optional Feature:
Macro: PC_GEN_RVC_EN
- Defined: adds input is_compressed (1 bit).
  - step = is_compressed ? 2 : 4.
  - Misalignment check uses bit[0] only; targets with bit[1]=1 are legal.
  - TRAP still clears mtvec bits[1:0].
- Undefined: port absent, step fixed at 4, misalignment checks bits[1:0].

Test Plan:
1. Reset with RESET=32'h8000_0000, release; fetch_ready=1 → cycle 1 fetch_valid=0 (BOOT), then pc=8000_0000, 8000_0004, 8000_0008; next_pc always pc+4.
2. pc=0x100, s_branch=1, s_branch_zero=1, alu_z=1, imm=-8 → pc=0x0F8. Repeat with alu_z=0 → pc=0x104.
3. pc=0x200, s_jump=1, s_jalr=1, alu_o=0x301 → pc=0x300. Same with stall=1 for 3 cycles → pc holds 0x200 until stall drops, then 0x300.
4. pc=0x40, s_jump=1, s_jalr=0, alu_o=0x122 → misaligned pulses 1 cycle, mepc=0x40, mcause=0, one fetch_valid=0 bubble, then pc=mtvec&~3 (mtvec=0x1003 → 0x1000). With PC_GEN_RVC_EN the same target is taken (pc=0x122, no trap).
5. trap=1, trap_cause=4'd11 while fetch_ready=0 at pc=0x500, same cycle as mret → TRAP entered, mepc=0x500, mcause=11; mret asserted later from RUN → pc=0x500.
6. Reset asserted in TRAP state → pc=RESET, mepc=0, mcause=0, fetch_valid=0 immediately (asynchronous); then normal BOOT→RUN sequence.
